// File: rtl/kmer_variant_sequencer.sv
// kmer_variant_sequencer: accepts one candidate read + kmer window and streams every edit variant of that kmer.
// Latency: first beat registered one cycle after acceptance, then one beat per cycle while out_ready is high.
// Backpressure: all beat outputs hold while out_valid & ~out_ready; in_ready reopens on the consumed final beat.
// Optional insertion/deletion variants (codes 4-8) are enabled by defining KMER_INDEL_VARIANTS_EN.
module kmer_variant_sequencer #(
  parameter int MAX_READ_BIT_WIDTH = 8,
  parameter int MAX_KMER_BIT_WIDTH = 6,
  parameter int EXTENSION_WIDTH    = 5,
  parameter int MIN_KMER_WIDTH     = 12,
  localparam int MAX_READ_WIDTH    = 2**MAX_READ_BIT_WIDTH,
  localparam int MAX_KMER_WIDTH    = 2**MAX_KMER_BIT_WIDTH,
  localparam int CANDIDATE_REGISTER_WIDTH = MAX_READ_WIDTH + EXTENSION_WIDTH + MAX_KMER_WIDTH - MIN_KMER_WIDTH,
  localparam int CW                = 2*(CANDIDATE_REGISTER_WIDTH + EXTENSION_WIDTH)
) (
  input  logic                            clk,
  input  logic                            rstb,
  input  logic                            flush,
  input  logic                            in_valid,
  output logic                            in_ready,
  input  logic [CW-1:0]                   candidate,
  input  logic signed [MAX_READ_BIT_WIDTH:0] position,
  input  logic [MAX_KMER_BIT_WIDTH:0]     kmer_length,
  input  logic                            direction,
  output logic                            out_valid,
  input  logic                            out_ready,
  output logic [2*MAX_KMER_WIDTH-1:0]     kmer_out,
  output logic [CW-1:0]                   candidate_out,
  output logic [3:0]                      variant_code,
  output logic signed [MAX_READ_BIT_WIDTH:0] mut_position,
  output logic                            out_last,
  output logic                            out_err
);

  localparam int PW  = MAX_READ_BIT_WIDTH + 1;   // position port width
  localparam int SW  = MAX_READ_BIT_WIDTH + 2;   // widened signed position arithmetic
  localparam int OW  = SW + 1;                   // bit offset into the candidate bus
  localparam int KLW = MAX_KMER_BIT_WIDTH + 1;   // kmer length width
  localparam int KMW = 2*MAX_KMER_WIDTH;         // kmer bus width
`ifdef KMER_INDEL_VARIANTS_EN
  localparam int CNTW = 4;
`else
  localparam int CNTW = 2;
`endif

  localparam logic signed [SW-1:0] LO_LIM = SW'(-EXTENSION_WIDTH);
  localparam logic signed [SW-1:0] HI_LIM = SW'(CANDIDATE_REGISTER_WIDTH - 1);
  localparam logic [KLW-1:0]       K_MIN  = KLW'(MIN_KMER_WIDTH);
  localparam logic [KLW-1:0]       K_MAX  = KLW'(MAX_KMER_WIDTH);

  typedef enum logic {S_IDLE, S_EMIT} state_t;

  state_t               state;
  logic [CW-1:0]        cand_q;
  logic signed [PW-1:0] pos_q;
  logic [KLW-1:0]       klen_q;
  logic                 dir_q;
  logic [CNTW-1:0]      cnt_q;

  logic                 accept;
  logic                 advance;

  // Beat builder sources: the live inputs on acceptance, otherwise the captured job.
  logic [CW-1:0]        src_cand;
  logic signed [PW-1:0] src_pos;
  logic [KLW-1:0]       src_klen;
  logic                 src_dir;
  logic [CNTW-1:0]      cnt_nxt;
  logic [3:0]           code_nxt;

  logic signed [SW-1:0] s_p, s_k, s_end, s_m;
  logic                 src_err;
  logic [SW-1:0]        p_idx, m_idx;
  logic [OW-1:0]        p_off, m_off;
  logic [KLW:0]         k_off, kidx_off;
  logic [KMW-1:0]       kwin, mask_k;
  logic [1:0]           orig, delta;
  logic [KMW-1:0]       sub_kmer;
  logic [CW-1:0]        sub_cand;
  logic [KMW-1:0]       nb_kmer;
  logic [CW-1:0]        nb_cand;
  logic                 nb_last;

  // A finishing job hands the slot straight to the next one; flush closes the door for its cycle.
  assign in_ready = ~flush & ((state == S_IDLE) | ((state == S_EMIT) & out_last & out_ready));
  assign accept   = in_valid & in_ready;
  assign advance  = out_valid & out_ready;

  assign src_cand = accept ? candidate   : cand_q;
  assign src_pos  = accept ? position    : pos_q;
  assign src_klen = accept ? kmer_length : klen_q;
  assign src_dir  = accept ? direction   : dir_q;
  assign cnt_nxt  = accept ? '0 : cnt_q + CNTW'(1);
  assign code_nxt = 4'(cnt_nxt);

  // Signed window arithmetic, one bit wider than the position so p+k-1 cannot wrap.
  assign s_p     = {src_pos[PW-1], src_pos};
  assign s_k     = {{(SW-KLW){1'b0}}, src_klen};
  assign s_end   = s_p + s_k - SW'(1);
  assign s_m     = src_dir ? s_end : s_p;
  assign src_err = (s_p < LO_LIM) | (s_end > HI_LIM) | (src_klen < K_MIN) | (src_klen > K_MAX);

  // Base b lives at bit 2*(b+EXT); offsets below are only meaningful for legal jobs.
  assign p_idx    = s_p + SW'(EXTENSION_WIDTH);
  assign m_idx    = s_m + SW'(EXTENSION_WIDTH);
  assign p_off    = {p_idx, 1'b0};
  assign m_off    = {m_idx, 1'b0};
  assign k_off    = {src_klen, 1'b0};
  assign kidx_off = src_dir ? {src_klen - KLW'(1), 1'b0} : '0;

  assign kwin   = KMW'(src_cand >> p_off);
  assign mask_k = ~({KMW{1'b1}} << k_off);
  assign orig   = 2'(src_cand >> m_off);
  assign delta  = orig ^ (orig + code_nxt[1:0]);

  // Substitution: XOR the base difference into the same base of both kmer and candidate.
  assign sub_kmer = (kwin & mask_k) ^ (KMW'(delta) << kidx_off);
  assign sub_cand = src_cand ^ (CW'(delta) << m_off);

`ifdef KMER_INDEL_VARIANTS_EN
  logic [KMW-1:0] mask_k1, kwin_s2, ins_kmer, del_kmer;
  logic [1:0]     top_base;
  logic           del_ok;

  assign mask_k1  = mask_k >> 2;
  assign kwin_s2  = KMW'(src_cand >> (p_off + OW'(2)));
  assign top_base = 2'(src_cand >> (p_off + OW'(k_off)));
  assign del_ok   = (s_p + s_k) <= HI_LIM;
  assign ins_kmer = src_dir ? ((kwin & mask_k1) | (KMW'(code_nxt[1:0]) << kidx_off))
                            : (((kwin << 2) | KMW'(code_nxt[1:0])) & mask_k);
  assign del_kmer = src_dir ? ((kwin & mask_k1) | (KMW'(top_base) << kidx_off))
                            : (kwin_s2 & mask_k);
`endif

  // Select the contents of the next beat from the variant code and the error check.
  always_comb begin
    nb_kmer = sub_kmer;
    nb_cand = sub_cand;
    nb_last = (code_nxt == 4'd3);
`ifdef KMER_INDEL_VARIANTS_EN
    nb_last = del_ok ? (code_nxt == 4'd8) : (code_nxt == 4'd7);
    if (code_nxt[3] | code_nxt[2]) begin
      nb_cand = src_cand;
      nb_kmer = code_nxt[3] ? del_kmer : ins_kmer;
    end
`endif
    if (src_err) begin
      nb_kmer = '0;
      nb_cand = src_cand;
      nb_last = 1'b1;
    end
  end

  // Sequencer FSM: capture on accept, register one beat per handshake, drop the job on flush.
  always_ff @(posedge clk or negedge rstb) begin
    if (!rstb) begin
      state         <= S_IDLE;
      cand_q        <= '0;
      pos_q         <= '0;
      klen_q        <= '0;
      dir_q         <= 1'b0;
      cnt_q         <= '0;
      out_valid     <= 1'b0;
      kmer_out      <= '0;
      candidate_out <= '0;
      variant_code  <= '0;
      mut_position  <= '0;
      out_last      <= 1'b0;
      out_err       <= 1'b0;
    end else if (flush) begin
      state     <= S_IDLE;
      out_valid <= 1'b0;
      out_last  <= 1'b0;
      out_err   <= 1'b0;
    end else if (accept || (advance && !out_last)) begin
      if (accept) begin
        cand_q <= candidate;
        pos_q  <= position;
        klen_q <= kmer_length;
        dir_q  <= direction;
      end
      state         <= S_EMIT;
      cnt_q         <= cnt_nxt;
      out_valid     <= 1'b1;
      kmer_out      <= nb_kmer;
      candidate_out <= nb_cand;
      variant_code  <= code_nxt;
      mut_position  <= s_m[PW-1:0];
      out_last      <= nb_last;
      out_err       <= src_err;
    end else if (advance) begin
      state     <= S_IDLE;
      out_valid <= 1'b0;
      out_last  <= 1'b0;
      out_err   <= 1'b0;
    end
  end

endmodule

// File: tb/tb_kmer_variant_sequencer.sv
// Bench for kmer_variant_sequencer: directed jobs followed by random jobs under random backpressure.
// Expected beats come from a base-array model of the edit rules kept in a queue.
// Every cycle compares handshake signals and the head beat against the model.
module tb_kmer_variant_sequencer;

  localparam int MRBW = 8;
  localparam int MKBW = 6;
  localparam int EXT  = 5;
  localparam int MINK = 12;
  localparam int MAXK = 2**MKBW;
  localparam int CRW  = 2**MRBW + EXT + MAXK - MINK;
  localparam int CW   = 2*(CRW + EXT);
  localparam int KMW  = 2*MAXK;
  localparam int PW   = MRBW + 1;
  localparam int KLW  = MKBW + 1;

  logic                 clk = 1'b0;
  logic                 rstb = 1'b0;
  logic                 flush = 1'b0;
  logic                 in_valid = 1'b0;
  logic                 in_ready;
  logic [CW-1:0]        candidate = '0;
  logic signed [PW-1:0] position = '0;
  logic [KLW-1:0]       kmer_length = '0;
  logic                 direction = 1'b0;
  logic                 out_valid;
  logic                 out_ready = 1'b0;
  logic [KMW-1:0]       kmer_out;
  logic [CW-1:0]        candidate_out;
  logic [3:0]           variant_code;
  logic signed [PW-1:0] mut_position;
  logic                 out_last;
  logic                 out_err;

  always #5 clk = ~clk;

  kmer_variant_sequencer dut (
    .clk           (clk),
    .rstb          (rstb),
    .flush         (flush),
    .in_valid      (in_valid),
    .in_ready      (in_ready),
    .candidate     (candidate),
    .position      (position),
    .kmer_length   (kmer_length),
    .direction     (direction),
    .out_valid     (out_valid),
    .out_ready     (out_ready),
    .kmer_out      (kmer_out),
    .candidate_out (candidate_out),
    .variant_code  (variant_code),
    .mut_position  (mut_position),
    .out_last      (out_last),
    .out_err       (out_err)
  );

  typedef struct {
    logic [KMW-1:0]       kmer;
    logic [CW-1:0]        cand;
    logic [3:0]           code;
    logic signed [PW-1:0] mpos;
    logic                 last;
    logic                 err;
  } beat_t;

  beat_t exp_q[$];
  int    n_chk = 0;
  int    n_pass = 0;
  int    n_fail = 0;
  int    rdy_mode = 0;
  int    cyc = 0;
  int    n_beats = 0;
  bit    accepted = 1'b0;

  task automatic chk(input string tag, input logic [CW-1:0] obs, input logic [CW-1:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [1:0] base_at(input logic [CW-1:0] c, input int b);
    logic [CW-1:0] t;
    t = c >> (2*(b + EXT));
    return t[1:0];
  endfunction

  // Expand one job into its expected beats using plain base arrays.
  function automatic void model_job(input logic [CW-1:0] c, input int p, input int k, input bit dir);
    int    m;
    int    nb;
    int    nbv;
    int    kb[MAXK];
    beat_t bt;
    m = dir ? p + k - 1 : p;
    bt.mpos = PW'(m);
    if ((p < -EXT) || (p + k - 1 > CRW - 1) || (k < MINK) || (k > MAXK)) begin
      bt.kmer = '0; bt.cand = c; bt.code = 4'd0; bt.last = 1'b1; bt.err = 1'b1;
      exp_q.push_back(bt);
      return;
    end
    nb = 4;
`ifdef KMER_INDEL_VARIANTS_EN
    nb = (p + k <= CRW - 1) ? 9 : 8;
`endif
    for (int v = 0; v < nb; v++) begin
      bt.cand = c;
      for (int i = 0; i < k; i++) kb[i] = base_at(c, p + i);
      if (v < 4) begin
        nbv = (base_at(c, m) + v) % 4;
        kb[m - p] = nbv;
        bt.cand[2*(m + EXT) +: 2] = 2'(nbv);
      end else if (v < 8) begin
        if (!dir) begin
          kb[0] = v - 4;
          for (int i = 1; i < k; i++) kb[i] = base_at(c, p + i - 1);
        end else begin
          kb[k - 1] = v - 4;
        end
      end else begin
        if (!dir) for (int i = 0; i < k; i++) kb[i] = base_at(c, p + 1 + i);
        else kb[k - 1] = base_at(c, p + k);
      end
      bt.kmer = '0;
      for (int i = 0; i < k; i++) bt.kmer[2*i +: 2] = 2'(kb[i]);
      bt.code = 4'(v);
      bt.last = (v == nb - 1);
      bt.err  = 1'b0;
      exp_q.push_back(bt);
    end
  endfunction

  function automatic logic [CW-1:0] rand_cand();
    logic [CW-1:0] r;
    r = '0;
    for (int i = 0; i < (CW + 31) / 32; i++) r = (r << 32) | CW'($urandom);
    return r;
  endfunction

  // One clock cycle: drive out_ready, check at the falling edge, update the model, cross the rising edge.
  task automatic step();
    bit exp_rdy;
    bit pop;
    bit acc;
    case (rdy_mode)
      0:       out_ready = 1'b1;
      1:       out_ready = ((cyc % 4) == 0) || ((cyc % 4) == 3);
      default: out_ready = 1'($urandom_range(0, 1));
    endcase
    cyc++;
    @(negedge clk);
    chk("out_valid", CW'(out_valid), CW'(exp_q.size() != 0));
    exp_rdy = !flush && ((exp_q.size() == 0) || (exp_q[0].last && out_ready));
    chk("in_ready", CW'(in_ready), CW'(exp_rdy));
    if (out_valid && exp_q.size() != 0) begin
      chk("kmer_out",      CW'(kmer_out),     CW'(exp_q[0].kmer));
      chk("candidate_out", candidate_out,     exp_q[0].cand);
      chk("variant_code",  CW'(variant_code), CW'(exp_q[0].code));
      chk("mut_position",  CW'(mut_position), CW'(exp_q[0].mpos));
      chk("out_last",      CW'(out_last),     CW'(exp_q[0].last));
      chk("out_err",       CW'(out_err),      CW'(exp_q[0].err));
    end
    pop = out_valid && out_ready && (exp_q.size() != 0);
    acc = in_valid && in_ready;
    if (pop) begin
      void'(exp_q.pop_front());
      n_beats++;
    end
    if (flush) exp_q.delete();
    if (acc) begin
      model_job(candidate, int'(position), int'(kmer_length), direction);
      accepted = 1'b1;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic offer(input logic [CW-1:0] c, input int p, input int k, input bit dir);
    candidate   = c;
    position    = PW'(p);
    kmer_length = KLW'(k);
    direction   = dir;
    in_valid    = 1'b1;
    accepted    = 1'b0;
    for (int i = 0; i < 200 && !accepted; i++) step();
    in_valid = 1'b0;
    chk("accept_timeout", CW'(accepted), CW'(1));
  endtask

  task automatic drain();
    for (int i = 0; i < 400 && exp_q.size() != 0; i++) step();
    chk("drain_timeout", CW'(exp_q.size()), CW'(0));
    step();
  endtask

  initial begin
    logic [CW-1:0] c;
    int            b0;

    // Reset values, sampled between clock edges.
    #12;
    chk("rst_out_valid", CW'(out_valid),     CW'(0));
    chk("rst_in_ready",  CW'(in_ready),      CW'(1));
    chk("rst_out_last",  CW'(out_last),      CW'(0));
    chk("rst_out_err",   CW'(out_err),       CW'(0));
    chk("rst_code",      CW'(variant_code),  CW'(0));
    chk("rst_kmer",      CW'(kmer_out),      CW'(0));
    chk("rst_cand",      candidate_out,      CW'(0));
    chk("rst_mpos",      CW'(mut_position),  CW'(0));
    rstb = 1'b1;
    @(posedge clk);
    #1;

    // All-A read, forward direction.
    rdy_mode = 0;
    offer('0, 0, 31, 1'b0);
    drain();

    // Base 30 = G, reverse direction mutates the top base of the kmer.
    c = '0;
    c[2*(30 + EXT) +: 2] = 2'b10;
    offer(c, 0, 31, 1'b1);
    drain();

    // Two jobs back-to-back: eight consecutive beats without a bubble.
    b0 = n_beats;
    offer(rand_cand(), 7, 20, 1'b0);
    offer(rand_cand(), 40, 33, 1'b1);
    drain();
    chk("b2b_beats", CW'(n_beats - b0), CW'(8));

    // Stall pattern 1,0,0,1 on out_ready.
    rdy_mode = 1;
    offer(rand_cand(), 100, 25, 1'b0);
    drain();
    rdy_mode = 0;

    // Range and length errors: one beat each.
    b0 = n_beats;
    offer(rand_cand(), -6, 31, 1'b0);
    drain();
    offer(rand_cand(), 0, 11, 1'b0);
    drain();
    chk("err_beats", CW'(n_beats - b0), CW'(2));

    // Flush during the second beat.
    offer(rand_cand(), 10, 20, 1'b0);
    step();
    flush = 1'b1;
    step();
    flush = 1'b0;
    step();
    step();

`ifdef KMER_INDEL_VARIANTS_EN
    // Window ending at the last base: deletion has no source base.
    b0 = n_beats;
    offer(rand_cand(), CRW - 60, 60, 1'b0);
    drain();
    chk("indel_edge_beats", CW'(n_beats - b0), CW'(8));
`endif

    // Reset in the middle of a job.
    offer(rand_cand(), 50, 40, 1'b1);
    step();
    rstb = 1'b0;
    #1;
    chk("midrst_out_valid", CW'(out_valid), CW'(0));
    chk("midrst_in_ready",  CW'(in_ready),  CW'(1));
    chk("midrst_out_last",  CW'(out_last),  CW'(0));
    exp_q.delete();
    #1;
    rstb = 1'b1;
    step();

    // Random jobs under random backpressure and random gaps.
    rdy_mode = 2;
    for (int j = 0; j < 40; j++) begin
      int gap;
      gap = $urandom_range(0, 2);
      for (int g = 0; g < gap; g++) step();
      offer(rand_cand(), int'($urandom_range(0, 263)) - 8, int'($urandom_range(10, 66)),
            1'($urandom_range(0, 1)));
    end
    drain();

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
